// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared pooling mode encodings, accumulator width helper and kernel legality mask
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Bit k is set when KERNEL=k is a supported window size.
  localparam logic [31:0] LEGAL_KERNEL_MASK = 32'h0000_0014;

  function automatic int acc_bits(input int activ_bits, input int kernel);
    return activ_bits + 2 * $clog2(kernel);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// rtl/pool_combine.sv - per-channel combine of a partial result with a pixel (unsigned max or sum)
module pool_combine #(
  parameter int AW = 8,
  parameter int PW = 8
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] pix,
  input  logic          avg,
  output logic [AW-1:0] res
);

  logic [AW-1:0] pix_w;

  always_comb begin
    pix_w = AW'(pix);
    if (avg) res = acc + pix_w;
    else     res = (acc > pix_w) ? acc : pix_w;
  end

endmodule

// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming KERNELxKERNEL pooling with a one-row partial-result buffer
// Optional average datapath compiled in with POOL2D_AVG_EN; otherwise max pooling only.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int CHANNELS   = 8,
  parameter int ACTIV_BITS = 8,
  parameter int KERNEL     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic [CHANNELS*ACTIV_BITS-1:0] in_data,
  input  logic                           in_sof,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS*ACTIV_BITS-1:0] out_data,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int OUT_W = IMG_W / KERNEL;
  localparam int OUT_H = IMG_H / KERNEL;
  localparam int KSH   = $clog2(KERNEL);
`ifdef POOL2D_AVG_EN
  localparam bit AVG_EN = 1'b1;
  localparam int AW     = acc_bits(ACTIV_BITS, KERNEL);
  localparam int SH     = 2 * KSH;
`else
  localparam bit AVG_EN = 1'b0;
  localparam int AW     = ACTIV_BITS;
`endif
  localparam bit KERNEL_OK = LEGAL_KERNEL_MASK[KERNEL];
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int OCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int DW  = CHANNELS * ACTIV_BITS;

  logic [CW-1:0]          col, cur_col;
  logic [RW-1:0]          row, cur_row;
  logic [OCW-1:0]         oc;
  logic                   mode_q, avg_sel, beat;
  logic                   in_region, win_first, win_last, frame_last;
  logic [CHANNELS*AW-1:0] acc [OUT_W];
  logic [CHANNELS*AW-1:0] acc_rd;
  wire  [CHANNELS*AW-1:0] acc_nx;
  wire  [DW-1:0]          out_nx;

  assign in_ready = !out_valid || out_ready;
  assign beat     = in_valid && in_ready;
  assign avg_sel  = AVG_EN && (mode_q == POOL_AVG);

  // An accepted start-of-frame beat is pixel (0,0) regardless of the counters.
  assign cur_col = in_sof ? '0 : col;
  assign cur_row = in_sof ? '0 : row;

  always_comb begin
    oc         = OCW'(cur_col >> KSH);
    in_region  = KERNEL_OK && (cur_col < CW'(OUT_W * KERNEL)) && (cur_row < RW'(OUT_H * KERNEL));
    win_first  = (cur_col[KSH-1:0] == '0) && (cur_row[KSH-1:0] == '0);
    win_last   = (&cur_col[KSH-1:0]) && (&cur_row[KSH-1:0]);
    frame_last = (oc == OCW'(OUT_W - 1)) && ((cur_row >> KSH) == RW'(OUT_H - 1));
    acc_rd     = acc[oc];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACTIV_BITS-1:0] pix;
    logic [AW-1:0]         comb, nxt;

    assign pix = in_data[c*ACTIV_BITS +: ACTIV_BITS];

    pool_combine #(.AW(AW), .PW(ACTIV_BITS)) u_combine (
      .acc (acc_rd[c*AW +: AW]),
      .pix (pix),
      .avg (avg_sel),
      .res (comb)
    );

    assign nxt                 = win_first ? AW'(pix) : comb;
    assign acc_nx[c*AW +: AW]  = nxt;
`ifdef POOL2D_AVG_EN
    assign out_nx[c*ACTIV_BITS +: ACTIV_BITS] = avg_sel ? nxt[SH +: ACTIV_BITS] : nxt[ACTIV_BITS-1:0];
`else
    assign out_nx[c*ACTIV_BITS +: ACTIV_BITS] = nxt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= POOL_MAX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else begin
      if (beat) begin
        if (cur_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
        if (cur_col == '0 && cur_row == '0) mode_q <= mode;
        if (in_region) acc[oc] <= acc_nx;
      end
      if (beat && in_region && win_last) begin
        out_valid <= 1'b1;
        out_last  <= frame_last;
        out_data  <= out_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - directed self-checking bench for pool2d_stream (4x4 and 5x5 frames, 2x2 windows)
module tb_pool2d_stream;

  logic       clk = 1'b0;
  logic       rst, mode, in_sof, out_ready, valid4, valid5;
  logic [7:0] in_data;
  logic       rdy4, rdy5, ov4, ov5, ol4, ol5;
  logic [7:0] od4, od5;
  logic [8:0] q4[$];
  logic [8:0] q5[$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  pool2d_stream #(.IMG_W(4), .IMG_H(4), .CHANNELS(1), .ACTIV_BITS(8), .KERNEL(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_sof(in_sof),
    .in_valid(valid4), .in_ready(rdy4), .out_data(od4), .out_last(ol4),
    .out_valid(ov4), .out_ready(out_ready)
  );

  pool2d_stream #(.IMG_W(5), .IMG_H(5), .CHANNELS(1), .ACTIV_BITS(8), .KERNEL(2)) dut5 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_sof(in_sof),
    .in_valid(valid5), .in_ready(rdy5), .out_data(od5), .out_last(ol5),
    .out_valid(ov5), .out_ready(out_ready)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (ov4 && out_ready) q4.push_back({ol4, od4});
      if (ov5 && out_ready) q5.push_back({ol5, od5});
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_q(input bit sel, input logic [7:0] e0, e1, e2, e3, input string tag);
    logic [8:0] got[$];
    logic [8:0] expv [4];
    if (sel) got = q5;
    else     got = q4;
    expv = '{{1'b0, e0}, {1'b0, e1}, {1'b0, e2}, {1'b1, e3}};
    check({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : 9'h1ff, expv[i]);
    q4.delete();
    q5.delete();
  endtask

  task automatic send(input bit sel, input logic [7:0] p, input bit sof);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_data = p;
    in_sof  = sof;
    if (sel) valid5 = 1'b1;
    else     valid4 = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = sel ? rdy5 : rdy4;
      @(posedge clk);
      #1;
      n++;
    end
    valid4 = 1'b0;
    valid5 = 1'b0;
    in_sof = 1'b0;
    check("beat_accept", ok, 1);
  endtask

  task automatic frame4(input bit sof_first);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send(1'b0, 8'(r * 4 + c), sof_first && r == 0 && c == 0);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_sof = 1'b0; valid4 = 1'b0; valid5 = 1'b0;
    out_ready = 1'b1; in_data = '0;
    #1;
    check("rst_out_valid", ov4, 0);
    check("rst_out_last", ol4, 0);
    check("rst_out_data", od4, 0);
    check("rst_in_ready", rdy4, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    frame4(1'b0);
    drain();
    check_q(1'b0, 5, 7, 13, 15, "max");

`ifdef POOL2D_AVG_EN
    mode = 1'b1;
    send(1'b0, 8'd0, 1'b0);
    mode = 1'b0;
    for (int i = 1; i < 16; i++) send(1'b0, 8'(i), 1'b0);
    drain();
    check_q(1'b0, 2, 4, 10, 12, "avg");
    frame4(1'b0);
    drain();
    check_q(1'b0, 5, 7, 13, 15, "avg_then_max");
`else
    mode = 1'b1;
    frame4(1'b0);
    mode = 1'b0;
    drain();
    check_q(1'b0, 5, 7, 13, 15, "mode_ignored");
`endif

    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 1'b0);
    check("bp_valid", ov4, 1);
    check("bp_data", od4, 5);
    check("bp_in_ready", rdy4, 0);
    in_data = 8'd6;
    valid4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_data", od4, 5);
    check("bp_hold_valid", ov4, 1);
    check("bp_hold_ready", rdy4, 0);
    valid4 = 1'b0;
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send(1'b0, 8'(i), 1'b0);
    drain();
    check_q(1'b0, 5, 7, 13, 15, "bp");

    for (int i = 0; i < 5; i++) send(1'b0, 8'd200, 1'b0);
    frame4(1'b1);
    drain();
    check_q(1'b0, 5, 7, 13, 15, "resync");

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        send(1'b1, (r < 4 && c < 4) ? 8'(r * 4 + c) : 8'd255, 1'b0);
    drain();
    check_q(1'b1, 5, 7, 13, 15, "rem");

    for (int i = 0; i < 7; i++) send(1'b0, 8'(i), 1'b0);
    out_ready = 1'b0;
    send(1'b0, 8'd7, 1'b0);
    check("pre_rst_valid", ov4, 1);
    check("pre_rst_data", od4, 7);
    in_data = 8'd8;
    valid4 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", ov4, 0);
    check("async_rst_data", od4, 0);
    check("async_rst_ready", rdy4, 1);
    valid4 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    q4.delete();
    frame4(1'b0);
    drain();
    check_q(1'b0, 5, 7, 13, 15, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
